acc_store_unit: RTL and testbench

//  Read side of the accumulator. On request, it snapshots the accumulator value and a

---
 rtl/acc_store_pkg.sv | 28 ++
 rtl/acc_store_unit_timeout_ctr.sv | 43 ++++
 rtl/acc_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_acc_store_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_store_pkg.sv
// -----------------------------------------------------------------------------
// acc_store_pkg
// Shared definitions for the accumulator store unit: default widths, timeout
// default and the FSM state encoding.
// Optional feature macro used by this slice: STORE_VERIFY_EN (read-back verify).
// -----------------------------------------------------------------------------
package acc_store_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_TIMEOUT = 15;

    // State encoding
    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_WRITE  = 3'd1;
    localparam logic [2:0] ENC_VERIFY = 3'd2;
    localparam logic [2:0] ENC_DONE   = 3'd3;
    localparam logic [2:0] ENC_ERR    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_WRITE  = ENC_WRITE,
        ST_VERIFY = ENC_VERIFY,
        ST_DONE   = ENC_DONE,
        ST_ERR    = ENC_ERR
    } state_t;

endpackage

// File: rtl/acc_store_unit_timeout_ctr.sv
// -----------------------------------------------------------------------------
// store_timeout_ctr
// Bounded-wait counter for the store unit. Counts edges spent waiting for a
// memory acknowledge.
// Ports:
//   i_clock   system clock, rising edge
//   i_reset   asynchronous active-high reset
//   i_clear   return the count to zero (has priority over i_enable)
//   i_enable  count this edge (a request is pending with no acknowledge)
//   o_expired high when this edge brings the count to TIMEOUT
// -----------------------------------------------------------------------------
module store_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    // Expiry is flagged on the edge that would take the count to TIMEOUT, so the
    // request stays high for exactly TIMEOUT cycles before the FSM aborts.
    assign o_expired = i_enable && (r_count == CW'(TIMEOUT - 1));

    // Wait counter: clear has priority, otherwise count while enabled
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/acc_store_unit.sv
// -----------------------------------------------------------------------------
// acc_store_unit
// Read side of the accumulator: on st_start it snapshots the accumulator value
// and the target address, then writes them to data memory over a req/ack
// handshake, aborting with an error pulse if memory never acknowledges.
// Optional macro STORE_VERIFY_EN adds a read-back VERIFY state after the write.
// Ports:
//   i_clock       system clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_st_start    start a store (sampled only in IDLE)
//   i_acc_data    accumulator value
//   i_st_addr     store target address
//   i_mem_ack     memory acknowledge (pulse or level)
//   i_mem_rdata   memory read data (used only with STORE_VERIFY_EN)
//   o_mem_req     memory request
//   o_mem_we      1 = write, 0 = read
//   o_mem_addr    captured address
//   o_mem_wdata   captured data
//   o_st_busy     high in every state except IDLE
//   o_st_done     one-cycle pulse on success
//   o_st_err      one-cycle pulse on timeout or verify mismatch
// -----------------------------------------------------------------------------
module acc_store_unit
    import acc_store_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_st_start,
    input  logic [DATA_W-1:0] i_acc_data,
    input  logic [ADDR_W-1:0] i_st_addr,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_st_busy,
    output logic              o_st_done,
    output logic              o_st_err
);

    state_t            r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_st_busy;
    logic              r_st_done;
    logic              r_st_err;

    logic w_waiting;
    logic w_ctr_clear;
    logic w_ctr_enable;
    logic w_expired;

    // A wait phase is any state holding mem_req high. An ack ends the phase
    // (and restarts the count for a following VERIFY), so it also clears.
    assign w_waiting    = (r_state == ST_WRITE) || (r_state == ST_VERIFY);
    assign w_ctr_clear  = !w_waiting || i_mem_ack;
    assign w_ctr_enable = w_waiting && !i_mem_ack;

    store_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (w_ctr_clear),
        .i_enable  (w_ctr_enable),
        .o_expired (w_expired)
    );

`ifndef STORE_VERIFY_EN
    // Read data only matters for the verify pass.
    logic w_unused_rdata;
    assign w_unused_rdata = ^i_mem_rdata;
`endif

    // Store FSM with registered handshake and status outputs
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_st_busy   <= 1'b0;
            r_st_done   <= 1'b0;
            r_st_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_st_done <= 1'b0;
                    r_st_err  <= 1'b0;
                    if (i_st_start) begin
                        // Snapshot now; later accumulator changes must not leak in.
                        r_mem_wdata <= i_acc_data;
                        r_mem_addr  <= i_st_addr;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_st_busy   <= 1'b1;
                        r_state     <= ST_WRITE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_WRITE: begin
                    // An ack on the expiry edge still counts as success.
                    if (i_mem_ack) begin
`ifdef STORE_VERIFY_EN
                        r_mem_we <= 1'b0;
                        r_state  <= ST_VERIFY;
`else
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_st_done <= 1'b1;
                        r_state   <= ST_DONE;
`endif
                    end else if (w_expired) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_st_err  <= 1'b1;
                        r_state   <= ST_ERR;
                    end else begin
                        r_state <= ST_WRITE;
                    end
                end

`ifdef STORE_VERIFY_EN
                ST_VERIFY: begin
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (i_mem_rdata == r_mem_wdata) begin
                            r_st_done <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_st_err <= 1'b1;
                            r_state  <= ST_ERR;
                        end
                    end else if (w_expired) begin
                        r_mem_req <= 1'b0;
                        r_st_err  <= 1'b1;
                        r_state   <= ST_ERR;
                    end else begin
                        r_state <= ST_VERIFY;
                    end
                end
`endif

                ST_DONE: begin
                    r_st_done <= 1'b0;
                    r_st_busy <= 1'b0;
                    r_state   <= ST_IDLE;
                end

                ST_ERR: begin
                    r_st_err  <= 1'b0;
                    r_st_busy <= 1'b0;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_st_busy <= 1'b0;
                    r_st_done <= 1'b0;
                    r_st_err  <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_st_busy   = r_st_busy;
    assign o_st_done   = r_st_done;
    assign o_st_err    = r_st_err;

endmodule

// File: tb/tb_acc_store_unit.sv
// -----------------------------------------------------------------------------
// tb_acc_store_unit
// Directed self-checking bench for acc_store_unit (DATA_W=8, ADDR_W=5,
// TIMEOUT=15). The verify scenario runs only when STORE_VERIFY_EN is defined.
// -----------------------------------------------------------------------------
module tb_acc_store_unit;

    logic       clk;
    logic       rst;
    logic       st_start;
    logic [7:0] acc_data;
    logic [4:0] st_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       mem_req;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       st_busy;
    logic       st_done;
    logic       st_err;

    int n_checks;
    int n_errors;

    acc_store_unit #(
        .DATA_W  (8),
        .ADDR_W  (5),
        .TIMEOUT (15)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_st_start  (st_start),
        .i_acc_data  (acc_data),
        .i_st_addr   (st_addr),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_st_busy   (st_busy),
        .o_st_done   (st_done),
        .o_st_err    (st_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle past it before sampling/driving
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int n;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        st_start  = 1'b0;
        acc_data  = 8'h00;
        st_addr   = 5'h00;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;

        // Reset state
        #3;
        check_val("rst_req",   32'(mem_req),   32'd0);
        check_val("rst_we",    32'(mem_we),    32'd0);
        check_val("rst_busy",  32'(st_busy),   32'd0);
        check_val("rst_done",  32'(st_done),   32'd0);
        check_val("rst_err",   32'(st_err),    32'd0);
        check_val("rst_addr",  32'(mem_addr),  32'd0);
        check_val("rst_wdata", 32'(mem_wdata), 32'd0);
        tick;
        rst = 1'b0;
        tick;

        // 1: basic store, ack on third request cycle
        acc_data = 8'hA5;
        st_addr  = 5'h1F;
        st_start = 1'b1;
        tick;
        st_start = 1'b0;
        check_val("t1_req1",  32'(mem_req),   32'd1);
        check_val("t1_we",    32'(mem_we),    32'd1);
        check_val("t1_wdata", 32'(mem_wdata), 32'hA5);
        check_val("t1_addr",  32'(mem_addr),  32'h1F);
        check_val("t1_busy",  32'(st_busy),   32'd1);
        tick;
        check_val("t1_req2",  32'(mem_req),   32'd1);
        tick;
        check_val("t1_req3",  32'(mem_req),   32'd1);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        check_val("t1_done",    32'(st_done), 32'd1);
        check_val("t1_req_off", 32'(mem_req), 32'd0);
        check_val("t1_no_err",  32'(st_err),  32'd0);
        tick;
        check_val("t1_done_pulse", 32'(st_done), 32'd0);
        check_val("t1_idle_busy",  32'(st_busy), 32'd0);

        // 2: accumulator changes while the request is pending
        acc_data = 8'h5A;
        st_addr  = 5'h03;
        st_start = 1'b1;
        tick;
        st_start = 1'b0;
        acc_data = 8'h00;
        for (int i = 0; i < 4; i++) begin
            check_val("t2_wdata_hold", 32'(mem_wdata), 32'h5A);
            tick;
        end
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        check_val("t2_done",       32'(st_done),   32'd1);
        check_val("t2_wdata_done", 32'(mem_wdata), 32'h5A);
        tick;

        // 3: no ack -> 15 request cycles then one error pulse
        st_start = 1'b1;
        tick;
        st_start = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick;
        end
        check_val("t3_req_cycles", 32'(n),       32'd15);
        check_val("t3_err",        32'(st_err),  32'd1);
        check_val("t3_no_done",    32'(st_done), 32'd0);
        tick;
        check_val("t3_err_pulse",  32'(st_err),  32'd0);
        check_val("t3_busy_off",   32'(st_busy), 32'd0);

        // 3b: ack on the expiry edge wins
        st_start = 1'b1;
        tick;
        st_start = 1'b0;
        repeat (14) tick;
        check_val("t3b_req15", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        check_val("t3b_done",   32'(st_done), 32'd1);
        check_val("t3b_no_err", 32'(st_err),  32'd0);
        tick;

        // 4: start while busy is ignored; ack in idle is ignored
        acc_data = 8'h11;
        st_addr  = 5'h0A;
        st_start = 1'b1;
        tick;
        st_start = 1'b0;
        tick;
        st_addr  = 5'h15;
        st_start = 1'b1;
        tick;
        st_start = 1'b0;
        check_val("t4_addr_kept", 32'(mem_addr), 32'h0A);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        check_val("t4_done", 32'(st_done), 32'd1);
        tick;
        check_val("t4_idle_busy", 32'(st_busy), 32'd0);
        tick;
        check_val("t4_no_second_req",  32'(mem_req), 32'd0);
        check_val("t4_no_second_busy", 32'(st_busy), 32'd0);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        check_val("t4_ack_idle_req",  32'(mem_req), 32'd0);
        check_val("t4_ack_idle_busy", 32'(st_busy), 32'd0);
        check_val("t4_ack_idle_done", 32'(st_done), 32'd0);
        check_val("t4_ack_idle_err",  32'(st_err),  32'd0);

        // 5: asynchronous reset mid-transfer
        st_start = 1'b1;
        tick;
        st_start = 1'b0;
        check_val("t5_req_before", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t5_req_async",  32'(mem_req), 32'd0);
        check_val("t5_busy_async", 32'(st_busy), 32'd0);
        check_val("t5_done_async", 32'(st_done), 32'd0);
        check_val("t5_err_async",  32'(st_err),  32'd0);
        #1;
        rst = 1'b0;
        tick;
        check_val("t5_stay_idle", 32'(st_busy), 32'd0);

`ifdef STORE_VERIFY_EN
        // 6: write then read-back verify, matching and mismatching
        acc_data = 8'h3C;
        st_addr  = 5'h07;
        st_start = 1'b1;
        tick;
        st_start = 1'b0;
        mem_ack  = 1'b1;
        tick;
        mem_ack  = 1'b0;
        check_val("t6_vreq",  32'(mem_req),  32'd1);
        check_val("t6_vwe",   32'(mem_we),   32'd0);
        check_val("t6_vaddr", 32'(mem_addr), 32'h07);
        mem_rdata = 8'h3C;
        mem_ack   = 1'b1;
        tick;
        mem_ack   = 1'b0;
        check_val("t6_match_done", 32'(st_done), 32'd1);
        check_val("t6_match_err",  32'(st_err),  32'd0);
        tick;
        tick;
        st_start = 1'b1;
        tick;
        st_start = 1'b0;
        mem_ack  = 1'b1;
        tick;
        mem_ack  = 1'b0;
        mem_rdata = 8'h3D;
        mem_ack   = 1'b1;
        tick;
        mem_ack   = 1'b0;
        check_val("t6_mismatch_err",  32'(st_err),  32'd1);
        check_val("t6_mismatch_done", 32'(st_done), 32'd0);
        tick;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
